// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared write-back select codes, width defaults and FSM state type
package pipe_pkg;

    localparam int XLEN_DEFAULT     = 32;
    localparam int MATRIX_W_DEFAULT = 128;

    localparam logic [1:0] W_SEL_NONE   = 2'b00;
    localparam logic [1:0] W_SEL_SCALAR = 2'b01;
    localparam logic [1:0] W_SEL_MATRIX = 2'b10;
    localparam logic [1:0] W_SEL_RSVD   = 2'b11;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/matrix_beat_asm.sv
// rtl/matrix_beat_asm.sv - packs XLEN memory beats into one MATRIX_W matrix word
module matrix_beat_asm
    import pipe_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int MATRIX_W = MATRIX_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                collect_i,
    input  logic                beat_valid_i,
    input  logic [XLEN-1:0]     beat_data_i,
    output logic [MATRIX_W-1:0] data_o,
    output logic                done_o
);

    localparam int BEATS = MATRIX_W / XLEN;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [MATRIX_W-1:0] buf_q, buf_d;
    logic                done;

    // Drop the current beat into its lane; data_o already includes the final beat
    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        done  = 1'b0;
        if (start_i) begin
            buf_d = '0;
            cnt_d = '0;
        end else if (collect_i && beat_valid_i) begin
            for (int i = 0; i < BEATS; i++) begin
                if (cnt_q == CW'(i)) begin
                    buf_d[i*XLEN +: XLEN] = beat_data_i;
                end
            end
            if (cnt_q == CW'(BEATS - 1)) begin
                done  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Lane buffer and beat counter; reset discards any partial assembly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            buf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            buf_q <= buf_d;
        end
    end

    assign data_o = buf_d;
    assign done_o = done;

endmodule

// File: rtl/stage_wb.sv
// rtl/stage_wb.sv - write-back stage; optional perf counters under STAGE_WB_PERF_CNT_EN
module stage_wb
    import pipe_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int MATRIX_W = MATRIX_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_valid,
    input  logic [1:0]          wb_w_select,
    input  logic                wb_mem2reg,
    input  logic                wb_matrix_load,
    input  logic [4:0]          wb_rd,
    input  logic [XLEN-1:0]     wb_alu_result,
    input  logic [XLEN-1:0]     wb_mem_data,
    input  logic [MATRIX_W-1:0] wb_matrix_alu,
    input  logic                mem_beat_valid,
    input  logic [XLEN-1:0]     mem_beat_data,
    output logic [1:0]          w_select,
    output logic [4:0]          w_regs_addr,
    output logic [XLEN-1:0]     w_regs_data,
    output logic [MATRIX_W-1:0] w_matrix_data,
    output logic                wb_stall,
`ifdef STAGE_WB_PERF_CNT_EN
    output logic [31:0]         perf_scalar_wr,
    output logic [31:0]         perf_matrix_wr,
    output logic [31:0]         perf_stall_cyc,
`endif
    output logic                beat_err
);

    wb_state_e           state_q, state_d;
    logic [4:0]          rd_q, rd_d;
    logic [1:0]          wsel_q, wsel_d;
    logic [4:0]          addr_q, addr_d;
    logic [XLEN-1:0]     data_q, data_d;
    logic [MATRIX_W-1:0] mdata_q, mdata_d;
    logic                beat_err_q, beat_err_d;
    logic                stall;
    logic                asm_start;
    logic                asm_done;
    logic [MATRIX_W-1:0] asm_data;

    matrix_beat_asm #(
        .XLEN     (XLEN),
        .MATRIX_W (MATRIX_W)
    ) u_asm (
        .clk          (clk),
        .rst          (rst),
        .start_i      (asm_start),
        .collect_i    (state_q == COLLECT),
        .beat_valid_i (mem_beat_valid),
        .beat_data_i  (mem_beat_data),
        .data_o       (asm_data),
        .done_o       (asm_done)
    );

    // Next-state, write-port mux and stall; data registers hold when nothing is written
    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        wsel_d     = W_SEL_NONE;
        addr_d     = addr_q;
        data_d     = data_q;
        mdata_d    = mdata_q;
        stall      = 1'b0;
        asm_start  = 1'b0;
        beat_err_d = beat_err_q | ((state_q == IDLE) && mem_beat_valid);
        case (state_q)
            IDLE: begin
                if (wb_valid) begin
                    case (wb_w_select)
                        W_SEL_SCALAR: begin
                            if (wb_rd != 5'd0) begin
                                wsel_d = W_SEL_SCALAR;
                                addr_d = wb_rd;
                                data_d = wb_mem2reg ? wb_mem_data : wb_alu_result;
                            end
                        end
                        W_SEL_MATRIX: begin
                            if (wb_matrix_load) begin
                                asm_start = 1'b1;
                                rd_d      = wb_rd;
                                stall     = 1'b1;
                                state_d   = COLLECT;
                            end else begin
                                wsel_d  = W_SEL_MATRIX;
                                addr_d  = wb_rd;
                                mdata_d = wb_matrix_alu;
                            end
                        end
                        default: wsel_d = W_SEL_NONE;
                    endcase
                end
            end
            COLLECT: begin
                stall = 1'b1;
                if (asm_done) begin
                    wsel_d  = W_SEL_MATRIX;
                    addr_d  = rd_q;
                    mdata_d = asm_data;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rd_q       <= '0;
            wsel_q     <= W_SEL_NONE;
            addr_q     <= '0;
            data_q     <= '0;
            mdata_q    <= '0;
            beat_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            wsel_q     <= wsel_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            mdata_q    <= mdata_d;
            beat_err_q <= beat_err_d;
        end
    end

    assign w_select      = wsel_q;
    assign w_regs_addr   = addr_q;
    assign w_regs_data   = data_q;
    assign w_matrix_data = mdata_q;
    assign wb_stall      = stall;
    assign beat_err      = beat_err_q;

`ifdef STAGE_WB_PERF_CNT_EN
    logic [31:0] perf_scalar_q, perf_matrix_q, perf_stall_q;

    // Free-running event counters, wrapping modulo 2^32
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_scalar_q <= '0;
            perf_matrix_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (wsel_q == W_SEL_SCALAR) perf_scalar_q <= perf_scalar_q + 32'd1;
            if (wsel_q == W_SEL_MATRIX) perf_matrix_q <= perf_matrix_q + 32'd1;
            if (stall)                  perf_stall_q  <= perf_stall_q + 32'd1;
        end
    end

    assign perf_scalar_wr = perf_scalar_q;
    assign perf_matrix_wr = perf_matrix_q;
    assign perf_stall_cyc = perf_stall_q;
`endif

endmodule
